// File: rtl/dma_ring_engine.sv
// dma_ring_engine: ring-pointer DMA engine; read and write bursts overlap through an internal FIFO
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   reg_wr_data, reg_wr_en    register write bus; one-hot strobe selects src_base, dest_base, tail_ptr,
//                             head_ptr, dma_size, ctrl_stat, ring_size (in that bit order)
//   src_base..ring_size       register contents; ctrl_stat = {done, 28'b0, busy, intr_en, en}
//   intr                      done & intr_en
//   rd_req_* / rd_*           read request channel and read data channel (engine is master)
//   wr_req_* / wr_*           write request channel and write data channel (engine is master)
module dma_ring_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           reg_wr_data,
    input  logic [6:0]            reg_wr_en,
    output logic [31:0]           src_base,
    output logic [31:0]           dest_base,
    output logic [31:0]           tail_ptr,
    output logic [31:0]           head_ptr,
    output logic [31:0]           dma_size,
    output logic [31:0]           ctrl_stat,
    output logic [31:0]           ring_size,
    output logic                  intr,
    output logic [31:0]           rd_req_addr,
    output logic [7:0]            rd_req_len,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic                  rd_last,
    output logic [31:0]           wr_req_addr,
    output logic [7:0]            wr_req_len,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  wr_last
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH = $clog2(BYTES);
    localparam int MSH = $clog2(MAX_BEATS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] STRIDE = 32'(MAX_BEATS * BYTES);
    localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_DATA = 2'd2, W_DONE = 2'd3;
    logic [1:0] rd_state, wr_state;
    logic [32:0] total_beats, n_bursts, last_beats, rd_idx, wr_idx, rd_beats, wr_beats;
    logic [7:0] wr_beat;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, free;
    logic busy, start, done_cyc, push, pop, full;
    logic [31:0] tail_sum, tail_next;

    // Burst geometry is derived live from dma_size, which cannot change while busy.
    assign total_beats = ({1'b0, dma_size} + 33'(BYTES - 1)) >> BSH;
    assign n_bursts = (total_beats + 33'(MAX_BEATS - 1)) >> MSH;
    assign last_beats = total_beats - ((n_bursts - 33'd1) << MSH);
    assign rd_beats = (rd_idx == n_bursts - 33'd1) ? last_beats : 33'(MAX_BEATS);
    assign wr_beats = (wr_idx == n_bursts - 33'd1) ? last_beats : 33'(MAX_BEATS);
    assign rd_req_len = 8'(rd_beats - 33'd1);
    assign wr_req_len = 8'(wr_beats - 33'd1);
    assign busy = ctrl_stat[2];
    assign start = !busy && ctrl_stat[0] && head_ptr != tail_ptr && dma_size != 32'd0;
    assign done_cyc = wr_state == W_DONE;
    assign intr = ctrl_stat[31] & ctrl_stat[1];
    assign tail_sum = tail_ptr + dma_size;
    assign tail_next = (ring_size != 32'd0 && tail_sum >= ring_size) ? tail_sum - ring_size : tail_sum;
    assign free = CW'(FIFO_DEPTH) - count;
    assign full = count == CW'(FIFO_DEPTH);
    // A read burst is only requested once the whole burst fits, so the FIFO can never overflow.
    assign rd_req_valid = rd_state == R_REQ && {{(33-CW){1'b0}}, free} >= rd_beats;
    assign rd_ready = rd_state == R_DATA && !full;
    assign push = rd_valid && rd_ready;
    // A write burst is only requested once all its beats are buffered, so wr_valid never stalls.
    assign wr_req_valid = wr_state == W_REQ && {{(33-CW){1'b0}}, count} >= wr_beats;
    assign wr_valid = wr_state == W_DATA;
    assign wr_data = mem[rptr];
    assign pop = wr_valid && wr_ready;
    assign wr_last = wr_valid && wr_beat == wr_req_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_base <= '0;
            dest_base <= '0;
            tail_ptr <= '0;
            head_ptr <= '0;
            dma_size <= '0;
            ctrl_stat <= '0;
            ring_size <= '0;
        end else begin
            if (reg_wr_en[0]) src_base <= reg_wr_data;
            if (reg_wr_en[1]) dest_base <= reg_wr_data;
            if (reg_wr_en[2] && !busy) tail_ptr <= reg_wr_data;
            if (reg_wr_en[3]) head_ptr <= reg_wr_data;
            if (reg_wr_en[4] && !busy) dma_size <= reg_wr_data;
            if (reg_wr_en[5]) ctrl_stat <= {reg_wr_data[31:3], busy, reg_wr_data[1:0]};
            if (reg_wr_en[6] && !busy) ring_size <= reg_wr_data;
            if (start) ctrl_stat[2] <= 1'b1;
            // Completion overrides a same-cycle software write of the done/busy bits.
            if (done_cyc) begin
                tail_ptr <= tail_next;
                ctrl_stat[31] <= 1'b1;
                ctrl_stat[2] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= R_IDLE;
            rd_idx <= '0;
            rd_req_addr <= '0;
        end else begin
            if (start) begin
                rd_state <= R_REQ;
                rd_idx <= '0;
                rd_req_addr <= src_base + tail_ptr;
            end else if (rd_req_valid && rd_req_ready) begin
                rd_state <= R_DATA;
            end else if (push && rd_last) begin
                rd_idx <= rd_idx + 33'd1;
                rd_req_addr <= rd_req_addr + STRIDE;
                rd_state <= (rd_idx + 33'd1 == n_bursts) ? R_IDLE : R_REQ;
            end
            if (done_cyc) rd_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state <= W_IDLE;
            wr_idx <= '0;
            wr_req_addr <= '0;
            wr_beat <= '0;
        end else begin
            if (start) begin
                wr_state <= W_REQ;
                wr_idx <= '0;
                wr_req_addr <= dest_base + tail_ptr;
            end else if (wr_req_valid && wr_req_ready) begin
                wr_state <= W_DATA;
                wr_beat <= '0;
            end else if (pop) begin
                wr_beat <= wr_beat + 8'd1;
                if (wr_last) begin
                    wr_idx <= wr_idx + 33'd1;
                    wr_req_addr <= wr_req_addr + STRIDE;
                    wr_state <= (wr_idx + 33'd1 == n_bursts) ? W_DONE : W_REQ;
                end
            end else if (done_cyc) begin
                wr_state <= W_IDLE;
                wr_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= rd_rdata;
    end
endmodule

// File: doc/dma_ring_engine.md
Name: dma_ring_engine

Overview:
- Parametrised successor to the single-channel DMA engine core.
- Moves buffers described by a ring of head/tail pointers from a source region to a destination region.
- Read and write bursts overlap through an internal FIFO, instead of alternating fill/drain phases.
- Burst length, data width and FIFO depth are configurable.
- Ring pointers wrap at a programmable ring size; completion raises a maskable interrupt.

Parameters:
DATA_WIDTH, 32, bus data width in bits (32/64/128); BYTES = DATA_WIDTH/8
MAX_BEATS, 8, maximum beats per burst (power of 2, 1..256)
FIFO_DEPTH, 16, internal FIFO entries (power of 2, >= MAX_BEATS)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
reg_wr_data  in  32  register write data
reg_wr_en  in  7  one-hot write strobe: [0]src_base [1]dest_base [2]tail_ptr [3]head_ptr [4]dma_size [5]ctrl_stat [6]ring_size
src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat, ring_size  out  32 each  register contents
intr  out  1  ctrl_stat[31] & ctrl_stat[1]
rd_req_addr  out  32  read burst byte address
rd_req_len  out  8  beats-1
rd_req_valid / rd_req_ready  out / in  1  read request handshake
rd_rdata  in  DATA_WIDTH  read beat data
rd_valid / rd_ready / rd_last  in / out / in  1  read data handshake
wr_req_addr  out  32  write burst byte address
wr_req_len  out  8  beats-1
wr_req_valid / wr_req_ready  out / in  1  write request handshake
wr_data  out  DATA_WIDTH  write beat data
wr_valid / wr_ready / wr_last  out / in / out  1  write data handshake

Behaviour:
Reset (rst low, async)
- All registers, counters, FIFO pointers and FSMs clear to 0/idle.
- All valid/ready/last outputs are 0.

Registers
- ctrl_stat[0] EN; [1] intr enable; [2] busy (read-only, write ignored); [31] done (sticky).
- Writes to tail_ptr, dma_size and ring_size are ignored while busy.
- A same-cycle ctrl_stat write and buffer completion: written bits land, but [31] ends at 1.

Buffer start (idle, busy=0)
- Condition: EN & head_ptr!=tail_ptr & dma_size!=0. Next cycle busy=1.
- Beat count = ceil(dma_size/BYTES). Bursts = ceil(beats/MAX_BEATS).
- Every burst is MAX_BEATS beats except the last, which carries the remainder.
- The last beat is full width; trailing bytes are don't-care.
- dma_size==0: no start, engine stays idle.

Read FSM: R_IDLE -> R_REQ -> R_DATA -> R_REQ/R_IDLE
- R_REQ asserts rd_req_valid only when FIFO free entries >= this burst's beats.
- rd_req_addr = src_base + tail_ptr + rd_burst_idx*MAX_BEATS*BYTES.
- Address and length are held stable until rd_req_ready.
- R_DATA: rd_ready = ~fifo_full. Each rd_valid&rd_ready pushes one entry.
- rd_last on an accepted beat increments rd_burst_idx; go to R_REQ, or R_IDLE once all bursts are read.

Write FSM: W_IDLE -> W_REQ -> W_DATA -> W_REQ/W_DONE
- W_REQ asserts wr_req_valid only when FIFO occupancy >= this burst's beats.
- wr_req_addr uses dest_base and wr_burst_idx, computed the same way as the read address.
- W_DATA: wr_valid=1 with wr_data = FIFO head (first-word-fall-through).
- Each wr_valid&wr_ready pops one entry. wr_last is asserted on beat index == wr_req_len.
- After the final burst: W_DONE for one cycle.

Completion (W_DONE)
- tail_ptr <= tail_ptr+dma_size; if result >= ring_size (and ring_size!=0), subtract ring_size.
- ctrl_stat[31] <= 1, busy <= 0, both burst indices clear.
- A new buffer may start on the following cycle.

FIFO
- Simultaneous push and pop leaves the count unchanged.
- It never overflows: read requests are gated by free space, and rd_ready is gated by full.

Mid-buffer events
- EN cleared: the current buffer completes, no new buffer starts.
- head_ptr written: takes effect for the next start check only.

Test Plan:
- src_base=0x1000, dest_base=0x8000, tail=0, head=0x40, dma_size=0x40, EN=1, DATA_WIDTH=32, MAX_BEATS=8 -> 2 read and 2 write bursts, len=7; write addresses 0x8000 and 0x8020; data matches; tail=0x40; intr=1 when ctrl_stat[1]=1.
- dma_size=0x24 -> bursts len=7 then len=0; last write at dest+0x20; tail advances by 0x24.
- ring_size=0x100, tail=0xE0, head=0x20, dma_size=0x40 -> first buffer reads src+0xE0 and tail wraps to 0x20; engine then idles because head==tail.
- wr_ready low for 20 cycles mid-burst with FIFO_DEPTH=16 -> rd_ready drops at full; no data loss; no read request issued without MAX_BEATS of free space.
- rst pulled low mid-burst -> all valids deassert immediately, registers read 0; after release with dma_size=0 and EN=1 there is no bus activity.
- ctrl_stat write with [31]=0 in the W_DONE cycle -> [31] reads 1; writing tail_ptr while busy leaves it unchanged.
